// File: rtl/bus_slave_controller.sv
//==============================================================================
// Module      : bus_slave_controller
// Description : Internal-bus register slave. A write handshake stores data_in
//               into one of NUM_REGS 32-bit registers. The read handshake
//               that follows returns two words: the register just addressed,
//               then status_in. Every handshake-wait state has a watchdog.
//               data_out and bus_handshake_2 are held at zero while the slave
//               is not driving, so several slaves can be OR-combined.
// Ports       : clk, reset (async, active-low)
//               register_address[7:0], register_address_valid  - decode
//               data_in[31:0], status_in[31:0]                  - data sources
//               bus_handshake_1 (strobe in), bus_handshake_2 (ack out)
//               data_out[31:0]                                  - read word
//               reg_file[32*NUM_REGS-1:0]                       - register image
//               reg_written (1-clk pulse), timeout_error (sticky)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_slave_controller #(
   parameter logic [7:0] BASE_ADDR = 8'h10,
   parameter int         NUM_REGS  = 4,
   parameter int         TIMEOUT   = 1000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               register_address,
   input  logic                     register_address_valid,
   input  logic [31:0]              data_in,
   output logic [31:0]              data_out,
   input  logic                     bus_handshake_1,
   output logic                     bus_handshake_2,
   input  logic [31:0]              status_in,
   output logic [32*NUM_REGS-1:0]   reg_file,
   output logic                     reg_written,
   output logic                     timeout_error
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WLATCH = 3'd1;
   localparam logic [2:0] S_WACK   = 3'd2;
   localparam logic [2:0] S_RWAIT  = 3'd3;
   localparam logic [2:0] S_RDRIVE = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   // Watchdog holds TIMEOUT-1 down to 0, so $clog2(TIMEOUT) bits suffice.
   localparam int              c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_WD_W-1:0] c_WD_LOAD = c_WD_W'(TIMEOUT - 1);

   // Address window compared in 9 bits so BASE_ADDR+NUM_REGS-1 cannot wrap.
   localparam logic [8:0] c_FIRST = {1'b0, BASE_ADDR};
   localparam logic [8:0] c_LAST  = c_FIRST + 9'(NUM_REGS) - 9'd1;

   logic [2:0]               r_state;
   logic [2:0]               w_next_state;
   logic [3:0]               r_idx;
   logic                     r_word_count;
   logic [c_WD_W-1:0]        r_wdog;
   logic                     r_timeout_error;
   logic [31:0]              r_rdata;
   logic [32*NUM_REGS-1:0]   r_reg_file;

   logic                     w_selected;
   logic                     w_in_wait;
   logic                     w_next_in_wait;
   logic                     w_timeout;
   logic                     w_wd_entry;
   logic [31:0]              w_sel_reg;

   assign w_selected = register_address_valid
                       && ({1'b0, register_address} >= c_FIRST)
                       && ({1'b0, register_address} <= c_LAST);

   assign w_in_wait = (r_state == S_WACK) || (r_state == S_RWAIT)
                      || (r_state == S_RDRIVE) || (r_state == S_DONE);
   assign w_next_in_wait = (w_next_state == S_WACK) || (w_next_state == S_RWAIT)
                           || (w_next_state == S_RDRIVE) || (w_next_state == S_DONE);

   assign w_timeout  = w_in_wait && (r_wdog == '0);
   // Any move into a wait state (including RDRIVE -> RWAIT) restarts the watchdog.
   assign w_wd_entry = w_next_in_wait && (w_next_state != r_state);

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic (watchdog expiry overrides every wait state)
   //---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_selected && bus_handshake_1) w_next_state = S_WLATCH;
         S_WLATCH: w_next_state = S_WACK;
         S_WACK:   if (!bus_handshake_1) w_next_state = S_RWAIT;
         S_RWAIT: begin
            // Abort has priority over a new strobe.
            if (!register_address_valid) w_next_state = S_IDLE;
            else if (bus_handshake_1)    w_next_state = S_RDRIVE;
         end
         S_RDRIVE: if (!bus_handshake_1) w_next_state = r_word_count ? S_DONE : S_RWAIT;
         S_DONE:   if (!register_address_valid) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
      if (w_timeout) w_next_state = S_IDLE;
   end

   //---------------------------------------------------------------------------
   // FSM: Moore outputs (state and registers only)
   //---------------------------------------------------------------------------
   always_comb begin
      bus_handshake_2 = 1'b0;
      data_out        = 32'h0;
      reg_written     = 1'b0;
      case (r_state)
         S_WLATCH: reg_written = 1'b1;
         S_WACK:   bus_handshake_2 = 1'b1;
         S_RDRIVE: begin
            bus_handshake_2 = 1'b1;
            data_out        = r_rdata;
         end
         default: ;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath
   //---------------------------------------------------------------------------
   always_comb begin
      w_sel_reg = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_idx == 4'(i)) w_sel_reg = r_reg_file[32*i +: 32];
      end
   end

   // Index is captured only when leaving IDLE; later address changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx <= 4'h0;
      end else if ((r_state == S_IDLE) && (w_next_state == S_WLATCH)) begin
         r_idx <= 4'(register_address - BASE_ADDR);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_reg_file <= '0;
      end else if (r_state == S_WLATCH) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == 4'(i)) r_reg_file[32*i +: 32] <= data_in;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_word_count <= 1'b0;
         r_rdata      <= 32'h0;
      end else begin
         if ((r_state == S_WACK) && (w_next_state == S_RWAIT))
            r_word_count <= 1'b0;
         else if ((r_state == S_RDRIVE) && !bus_handshake_1 && !w_timeout)
            r_word_count <= 1'b1;   // saturates: at most two words per transaction

         if ((r_state == S_RWAIT) && (w_next_state == S_RDRIVE))
            r_rdata <= r_word_count ? status_in : w_sel_reg;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wdog          <= '0;
         r_timeout_error <= 1'b0;
      end else begin
         if (w_wd_entry)
            r_wdog <= c_WD_LOAD;
         else if (w_in_wait && (r_wdog != '0))
            r_wdog <= r_wdog - c_WD_W'(1);

         if (w_timeout) r_timeout_error <= 1'b1;
      end
   end

   assign reg_file      = r_reg_file;
   assign timeout_error = r_timeout_error;

endmodule

`default_nettype wire

// File: tb/tb_bus_slave_controller.sv
//==============================================================================
// Module      : tb_bus_slave_controller
// Description : Directed self-checking bench for bus_slave_controller
//               (BASE_ADDR=8'h10, NUM_REGS=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bus_slave_controller;

   logic          clk;
   logic          reset;
   logic [7:0]    register_address;
   logic          register_address_valid;
   logic [31:0]   data_in;
   logic [31:0]   data_out;
   logic          bus_handshake_1;
   logic          bus_handshake_2;
   logic [31:0]   status_in;
   logic [127:0]  reg_file;
   logic          reg_written;
   logic          timeout_error;

   int n_cmp;
   int n_bad;
   logic [127:0] exp_regs;

   bus_slave_controller #(
      .BASE_ADDR (8'h10),
      .NUM_REGS  (4),
      .TIMEOUT   (8)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .register_address       (register_address),
      .register_address_valid (register_address_valid),
      .data_in                (data_in),
      .data_out               (data_out),
      .bus_handshake_1        (bus_handshake_1),
      .bus_handshake_2        (bus_handshake_2),
      .status_in              (status_in),
      .reg_file               (reg_file),
      .reg_written            (reg_written),
      .timeout_error          (timeout_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; sample and drive 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write + two-word read; returns the words seen in RDRIVE.
   task automatic do_txn(input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] status,
                         output logic [31:0] rd0, output logic [31:0] rd1);
      register_address = addr; register_address_valid = 1'b1;
      data_in = wdata; status_in = status; bus_handshake_1 = 1'b1;
      tick();                          // WLATCH
      tick();                          // WACK
      bus_handshake_1 = 1'b0; tick();  // RWAIT
      bus_handshake_1 = 1'b1; tick();  // RDRIVE word 0
      rd0 = data_out;
      bus_handshake_1 = 1'b0; tick();  // RWAIT
      bus_handshake_1 = 1'b1; tick();  // RDRIVE word 1
      rd1 = data_out;
      bus_handshake_1 = 1'b0; tick();  // DONE
      register_address_valid = 1'b0; tick(); // IDLE
   endtask

   task automatic test_reset();
      reset = 1'b0;
      register_address = 8'h0; register_address_valid = 1'b0;
      data_in = 32'h0; status_in = 32'h0; bus_handshake_1 = 1'b0;
      exp_regs = '0;
      #2;
      n_cmp++; if (reg_file !== 128'h0) begin n_bad++; $display("FAIL rst_regs: got %h want 0", reg_file); end
      n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL rst_data_out: got %h want 0", data_out); end
      n_cmp++; if (bus_handshake_2 !== 1'b0) begin n_bad++; $display("FAIL rst_hs2: got %b want 0", bus_handshake_2); end
      n_cmp++; if (reg_written !== 1'b0) begin n_bad++; $display("FAIL rst_reg_written: got %b want 0", reg_written); end
      n_cmp++; if (timeout_error !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", timeout_error); end
      @(negedge clk); reset = 1'b1;
      tick();
      n_cmp++; if (bus_handshake_2 !== 1'b0) begin n_bad++; $display("FAIL rst_release_hs2: got %b want 0", bus_handshake_2); end
   endtask

   task automatic test_write_read();
      register_address = 8'h12; register_address_valid = 1'b1;
      data_in = 32'hDEADBEEF; status_in = 32'h00000055; bus_handshake_1 = 1'b1;
      tick();  // WLATCH
      n_cmp++; if (reg_written !== 1'b1) begin n_bad++; $display("FAIL wr_pulse: got %b want 1", reg_written); end
      n_cmp++; if (bus_handshake_2 !== 1'b0) begin n_bad++; $display("FAIL wr_latch_hs2: got %b want 0", bus_handshake_2); end
      tick();  // WACK
      exp_regs[64 +: 32] = 32'hDEADBEEF;
      n_cmp++; if (reg_file !== exp_regs) begin n_bad++; $display("FAIL wr_reg2: got %h want %h", reg_file, exp_regs); end
      n_cmp++; if (reg_written !== 1'b0) begin n_bad++; $display("FAIL wr_pulse_end: got %b want 0", reg_written); end
      n_cmp++; if (bus_handshake_2 !== 1'b1) begin n_bad++; $display("FAIL wr_ack_hs2: got %b want 1", bus_handshake_2); end
      // Address change mid-transaction must not move the read index.
      register_address = 8'h10;
      bus_handshake_1 = 1'b0; tick();  // RWAIT
      n_cmp++; if (bus_handshake_2 !== 1'b0) begin n_bad++; $display("FAIL rd_wait_hs2: got %b want 0", bus_handshake_2); end
      n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL rd_wait_data: got %h want 0", data_out); end
      bus_handshake_1 = 1'b1; tick();  // RDRIVE word 0
      n_cmp++; if (data_out !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_word0: got %h want DEADBEEF", data_out); end
      n_cmp++; if (bus_handshake_2 !== 1'b1) begin n_bad++; $display("FAIL rd_word0_hs2: got %b want 1", bus_handshake_2); end
      bus_handshake_1 = 1'b0; tick();  // RWAIT
      bus_handshake_1 = 1'b1; tick();  // RDRIVE word 1
      n_cmp++; if (data_out !== 32'h00000055) begin n_bad++; $display("FAIL rd_word1: got %h want 00000055", data_out); end
      bus_handshake_1 = 1'b0; tick();  // DONE
      n_cmp++; if ((bus_handshake_2 !== 1'b0) || (data_out !== 32'h0)) begin n_bad++; $display("FAIL rd_done_idle: got hs2=%b data=%h want 0/0", bus_handshake_2, data_out); end
      n_cmp++; if (reg_written !== 1'b0) begin n_bad++; $display("FAIL rd_no_rewrite: got %b want 0", reg_written); end
      register_address_valid = 1'b0; tick();  // IDLE
   endtask

   task automatic test_unselected();
      logic saw_activity;
      saw_activity = 1'b0;
      register_address = 8'h05; register_address_valid = 1'b1;
      data_in = 32'h12345678; status_in = 32'hFFFFFFFF;
      for (int i = 0; i < 8; i++) begin
         bus_handshake_1 = i[0] ? 1'b0 : 1'b1;
         tick();
         if ((bus_handshake_2 !== 1'b0) || (data_out !== 32'h0) || (reg_written !== 1'b0))
            saw_activity = 1'b1;
      end
      bus_handshake_1 = 1'b0; register_address_valid = 1'b0; tick();
      n_cmp++; if (saw_activity !== 1'b0) begin n_bad++; $display("FAIL unsel_outputs: got activity=%b want 0", saw_activity); end
      n_cmp++; if (reg_file !== exp_regs) begin n_bad++; $display("FAIL unsel_regs: got %h want %h", reg_file, exp_regs); end
   endtask

   task automatic test_abort();
      register_address = 8'h13; register_address_valid = 1'b1;
      data_in = 32'h0BADF00D; bus_handshake_1 = 1'b1;
      tick(); tick();                  // WLATCH, WACK
      exp_regs[96 +: 32] = 32'h0BADF00D;
      bus_handshake_1 = 1'b0; tick();  // RWAIT
      bus_handshake_1 = 1'b1; tick();  // RDRIVE word 0
      n_cmp++; if (data_out !== 32'h0BADF00D) begin n_bad++; $display("FAIL abort_word0: got %h want 0BADF00D", data_out); end
      bus_handshake_1 = 1'b0; tick();  // RWAIT
      // Abort and strobe together: abort wins.
      register_address_valid = 1'b0; bus_handshake_1 = 1'b1; tick();
      n_cmp++; if ((bus_handshake_2 !== 1'b0) || (data_out !== 32'h0)) begin n_bad++; $display("FAIL abort_idle: got hs2=%b data=%h want 0/0", bus_handshake_2, data_out); end
      tick();
      n_cmp++; if (bus_handshake_2 !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b want 0", bus_handshake_2); end
      bus_handshake_1 = 1'b0; tick();
      n_cmp++; if (reg_file !== exp_regs) begin n_bad++; $display("FAIL abort_regs: got %h want %h", reg_file, exp_regs); end
   endtask

   task automatic test_timeout();
      int ack_cycles;
      register_address = 8'h11; register_address_valid = 1'b1;
      data_in = 32'hA5A5A5A5; bus_handshake_1 = 1'b1;
      tick(); tick();                  // WLATCH, WACK (hold strobe)
      exp_regs[32 +: 32] = 32'hA5A5A5A5;
      ack_cycles = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus_handshake_2 !== 1'b1) break;
         ack_cycles++;
      end
      register_address_valid = 1'b0; bus_handshake_1 = 1'b0;
      n_cmp++; if (ack_cycles != 8) begin n_bad++; $display("FAIL to_ack_cycles: got %0d want 8", ack_cycles); end
      n_cmp++; if (timeout_error !== 1'b1) begin n_bad++; $display("FAIL to_flag_set: got %b want 1", timeout_error); end
      n_cmp++; if (reg_file !== exp_regs) begin n_bad++; $display("FAIL to_regs: got %h want %h", reg_file, exp_regs); end
      repeat (5) tick();
      n_cmp++; if (timeout_error !== 1'b1) begin n_bad++; $display("FAIL to_flag_sticky: got %b want 1", timeout_error); end
   endtask

   task automatic test_reset_in_rdrive();
      register_address = 8'h10; register_address_valid = 1'b1;
      data_in = 32'h11223344; bus_handshake_1 = 1'b1;
      tick(); tick();
      bus_handshake_1 = 1'b0; tick();
      bus_handshake_1 = 1'b1; tick();  // RDRIVE
      n_cmp++; if (data_out !== 32'h11223344) begin n_bad++; $display("FAIL rstrd_word0: got %h want 11223344", data_out); end
      #2 reset = 1'b0;
      #1;  // no clock edge in between
      n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL rstrd_data: got %h want 0", data_out); end
      n_cmp++; if (bus_handshake_2 !== 1'b0) begin n_bad++; $display("FAIL rstrd_hs2: got %b want 0", bus_handshake_2); end
      n_cmp++; if (reg_file !== 128'h0) begin n_bad++; $display("FAIL rstrd_regs: got %h want 0", reg_file); end
      n_cmp++; if (timeout_error !== 1'b0) begin n_bad++; $display("FAIL rstrd_timeout: got %b want 0", timeout_error); end
      exp_regs = '0;
      bus_handshake_1 = 1'b0; register_address_valid = 1'b0;
      @(negedge clk); reset = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, a1, b0, b1;
      do_txn(8'h10, 32'hCAFE0001, 32'h00000077, a0, a1);
      do_txn(8'h13, 32'hCAFE0004, 32'h00000088, b0, b1);
      exp_regs[0  +: 32] = 32'hCAFE0001;
      exp_regs[96 +: 32] = 32'hCAFE0004;
      n_cmp++; if (a0 !== 32'hCAFE0001) begin n_bad++; $display("FAIL b2b_a_word0: got %h want CAFE0001", a0); end
      n_cmp++; if (a1 !== 32'h00000077) begin n_bad++; $display("FAIL b2b_a_word1: got %h want 00000077", a1); end
      n_cmp++; if (b0 !== 32'hCAFE0004) begin n_bad++; $display("FAIL b2b_b_word0: got %h want CAFE0004", b0); end
      n_cmp++; if (b1 !== 32'h00000088) begin n_bad++; $display("FAIL b2b_b_word1: got %h want 00000088", b1); end
      n_cmp++; if (reg_file !== exp_regs) begin n_bad++; $display("FAIL b2b_regs: got %h want %h", reg_file, exp_regs); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_write_read();
      test_unselected();
      test_abort();
      test_timeout();
      test_reset_in_rdrive();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bus_slave_controller.md
BUS_SLAVE_CONTROLLER -- requirements
Module: bus_slave_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10, first register address decoded by this slave.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers held (range 1..16).
REQ-003 SHALL have parameter TIMEOUT, default 1000, maximum clocks spent in any handshake-wait state.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 register_address  input  8  internal-bus register address.
REQ-007 register_address_valid  input  1  high while register_address is stable for a transaction.
REQ-008 data_in  input  32  word from master (uP interface) to subsystems.
REQ-009 data_out  output  32  word from this slave to master; all-zero when not driving, so slaves OR-combine.
REQ-010 bus_handshake_1  input  1  master strobe.
REQ-011 bus_handshake_2  output  1  slave acknowledge; 0 whenever unselected, for OR-combining.
REQ-012 status_in  input  32  subsystem status word, returned as second read word.
REQ-013 reg_file  output  32*NUM_REGS  packed register contents; reg[i] at bits 32*i+31:32*i.
REQ-014 reg_written  output  1  one-clock pulse when any register is written.
REQ-015 timeout_error  output  1  sticky flag, set on watchdog expiry.

Function
REQ-016 selected SHALL be register_address_valid AND BASE_ADDR <= register_address <= BASE_ADDR+NUM_REGS-1; idx = register_address - BASE_ADDR, 4 bits, latched in S_IDLE on exit.
REQ-017 States SHALL be S_IDLE, S_WLATCH, S_WACK, S_RWAIT, S_RDRIVE, S_DONE.
REQ-018 S_IDLE: selected AND bus_handshake_1=1 -> S_WLATCH; otherwise stay.
REQ-019 S_WLATCH: reg[idx] <= data_in, reg_written=1 for this clock; unconditionally -> S_WACK.
REQ-020 S_WACK: bus_handshake_2=1; bus_handshake_1=0 -> S_RWAIT, word_count <= 0.
REQ-021 S_RWAIT: bus_handshake_2=0; register_address_valid=0 -> S_IDLE; bus_handshake_1=1 -> S_RDRIVE, data_out register loaded with reg[idx] if word_count=0, else status_in.
REQ-022 S_RDRIVE: bus_handshake_2=1, data_out = loaded word; bus_handshake_1=0 -> word_count+1; if word_count was 1 -> S_DONE else S_RWAIT.
REQ-023 S_DONE: outputs idle; register_address_valid=0 -> S_IDLE.
REQ-024 Exactly two words SHALL be returned per transaction; word_count is 1 bit, no wrap beyond 1.
REQ-025 data_out SHALL be 32'h0 in all states except S_RDRIVE; bus_handshake_2 SHALL be 1 only in S_WACK and S_RDRIVE.
REQ-026 bus_handshake_2 and data_out SHALL be Moore outputs (decoded from state/registers only, no combinational path from inputs).
REQ-027 Watchdog counter SHALL load TIMEOUT-1 on entry to S_WACK, S_RWAIT, S_RDRIVE, S_DONE, decrement each clock there; at zero -> S_IDLE, timeout_error <= 1.
REQ-028 timeout_error SHALL clear only on reset.
REQ-029 Address change while not in S_IDLE SHALL be ignored; idx stays latched.
REQ-030 Unselected address with bus_handshake_1=1 SHALL leave all outputs at idle values and registers unchanged.
REQ-031 A write to idx addressing beyond NUM_REGS cannot occur (REQ-016 excludes it).
REQ-032 S_RWAIT abort (register_address_valid low) SHALL take priority over bus_handshake_1.

Reset
REQ-033 On reset low: state S_IDLE, all reg[i]=0, data_out=0, bus_handshake_2=0, reg_written=0, timeout_error=0, word_count=0, watchdog=0, regardless of phase; takes effect without clock.
REQ-034 Reset release SHALL be synchronised by the user; block resumes in S_IDLE on first clock after release.

Verification
REQ-035 Write 32'hDEADBEEF to BASE_ADDR+2, full handshake, status_in=32'h00000055 -> reg[2]=DEADBEEF, reg_written one pulse, read words DEADBEEF then 00000055.
REQ-036 Address 8'h05 (unselected) full transaction -> bus_handshake_2 and data_out stay 0, reg_file unchanged.
REQ-037 Master holds bus_handshake_1 high after write ack, TIMEOUT=8 -> return to S_IDLE after 8 clocks, timeout_error=1, stays 1 until reset.
REQ-038 Deassert register_address_valid in S_RWAIT before second word -> S_IDLE next clock, bus_handshake_2=0.
REQ-039 Assert reset while in S_RDRIVE -> data_out=0, bus_handshake_2=0, all registers 0 immediately.
REQ-040 Back-to-back transactions to BASE_ADDR and BASE_ADDR+3 -> both registers written, each returns own value first.
